layer_lut_pipe: RTL and testbench

LAYER_LUT_PIPE -- requirements
Module: layer_lut_pipe

---
 rtl/layer_lut_pipe.sv | 91 +++++++++
 tb/tb_layer_lut_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_lut_pipe.sv
// Layer of independent neuron lookup tables behind a two-stage valid/ready pipeline.
// S1 captures the input vector; S2 registers the per-neuron table lookups.
module layer_lut_pipe #(
  parameter int NEURONS = 4,
  parameter int IN_W    = 4,
  parameter int OUT_W   = 2,
  parameter int NB      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [NB-1:0]            cfg_neuron,
  input  logic [IN_W-1:0]          cfg_addr,
  input  logic [OUT_W-1:0]         cfg_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NEURONS*IN_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NEURONS*OUT_W-1:0] out_data,
  output logic [15:0]              lookup_cnt
);

  localparam int DEPTH = 1 << IN_W;

  logic                     adv1;
  logic                     adv2;
  logic                     s1_valid_q, s1_valid_d;
  logic [NEURONS*IN_W-1:0]  s1_data_q,  s1_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [NEURONS*OUT_W-1:0] out_data_q,  out_data_d;
  logic [NEURONS*OUT_W-1:0] lut_rd;
  logic [15:0]              cnt_q, cnt_d;

  // Select values at or above NEURONS never match a generated index, so such writes are dropped.
  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    logic [OUT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (cfg_we && (cfg_neuron == NB'(gi))) begin
        mem[cfg_addr] <= cfg_data;
      end
    end

    assign lut_rd[gi*OUT_W +: OUT_W] = mem[s1_data_q[gi*IN_W +: IN_W]];
  end

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !cfg_we;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      out_data_d  = lut_rd;
    end
    if (adv1) begin
      s1_valid_d = in_valid && in_ready;
      s1_data_d  = in_data;
    end
    if (out_valid_q && out_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign lookup_cnt = cnt_q;

endmodule

// File: tb/tb_layer_lut_pipe.sv
// Bench for layer_lut_pipe: slot-based reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, counter saturation.
module tb_layer_lut_pipe;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_neuron;
  logic [IW-1:0] cfg_addr;
  logic [OW-1:0] cfg_data;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [15:0]   lookup_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  layer_lut_pipe #(.NEURONS(N), .IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .lookup_cnt(lookup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two slots (stage-1 vector, output result) plus tables and a counter.
  logic [1:0]  m_tbl [N][16];
  logic        m_s1_v = 1'b0;
  logic [15:0] m_s1_a;
  logic        m_out_v = 1'b0;
  logic [7:0]  m_out;
  logic [15:0] m_cnt;
  logic        armed = 1'b0;
  logic        exp_rdy;
  logic        c_rst, c_we, c_iv, c_ordy;
  logic [1:0]  c_nrn;
  logic [3:0]  c_addr;
  logic [1:0]  c_dat;
  logic [15:0] c_data;

  function automatic logic [7:0] m_lookup(input logic [15:0] a);
    logic [7:0] r;
    for (int k = 0; k < N; k++) r[k*2 +: 2] = m_tbl[k][a[k*4 +: 4]];
    return r;
  endfunction

  always begin
    @(negedge clk);
    c_rst = rst; c_we = cfg_we; c_iv = in_valid; c_ordy = out_ready;
    c_nrn = cfg_neuron; c_addr = cfg_addr; c_dat = cfg_data; c_data = in_data;
    // A vector can enter unless both slots are occupied with the output stalled, or a write is underway.
    exp_rdy = !(m_s1_v && m_out_v && !c_ordy) && !c_we;
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_out_v));
      if (m_out_v) check("out_data", 32'(out_data), 32'(m_out));
      check("lookup_cnt", 32'(lookup_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (c_rst) begin
      m_s1_v = 1'b0; m_out_v = 1'b0; m_out = 8'h00; m_cnt = 16'd0; armed = 1'b1;
    end else begin
      if (m_out_v && c_ordy) begin
        m_out_v = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (!m_out_v) begin
        m_out_v = m_s1_v;
        m_out   = m_lookup(m_s1_a);
        m_s1_v  = 1'b0;
      end
      if (!m_s1_v) begin
        m_s1_v = c_iv && exp_rdy;
        m_s1_a = c_data;
      end
    end
    if (c_we && (int'(c_nrn) < N)) m_tbl[c_nrn][c_addr] = c_dat;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] lit_exp(input logic [15:0] a);
    return (a[1:0] == 2'b00) ? 8'h03 : 8'h00;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sv [8];
    logic [15:0] vs [3];
    int idx;
    int bound;

    rst = 1'b1; cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_cnt", 32'(lookup_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < 16; a++) begin
        cfg_we = 1'b1; cfg_neuron = 2'(n); cfg_addr = 4'(a);
        cfg_data = (n == 0 && a[1:0] == 2'b00) ? 2'b11 : 2'b00;
        tick();
      end
    end
    cfg_we = 1'b0;

    send(16'h0004);
    tick();
    check("v4_valid", 32'(out_valid), 32'h1);
    check("v4_data", 32'(out_data), 32'h03);
    tick();
    check("v4_cnt", 32'(lookup_cnt), 32'd1);

    send(16'h0002);
    tick();
    check("v2_data", 32'(out_data), 32'h00);
    tick();
    check("v2_cnt", 32'(lookup_cnt), 32'd2);

    for (int i = 0; i < 8; i++) sv[i] = 16'($urandom);
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_data  = (i < 8) ? sv[i] : 16'h0;
      tick();
      check("stream_valid", 32'(out_valid), 32'((i >= 1) && (i <= 8)));
      if (i >= 1 && i <= 8) check("stream_data", 32'(out_data), 32'(lit_exp(sv[i-1])));
    end
    check("stream_cnt", 32'(lookup_cnt), 32'd10);

    vs[0] = 16'h0004; vs[1] = 16'h0001; vs[2] = 16'h0000;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = vs[idx];
      #1;
      if (in_ready) idx++;
      tick();
    end
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_data", 32'(out_data), 32'h03);
    out_ready = 1'b1;
    bound = 0;
    while (idx < 3 && bound < 10) begin
      in_data = vs[idx];
      #1;
      if (in_ready) idx++;
      tick();
      bound++;
    end
    check("stall_release", 32'(idx), 32'd3);
    in_valid = 1'b0;
    repeat (4) tick();
    check("stall_cnt", 32'(lookup_cnt), 32'd13);

    send(16'h0004);
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 4'd4; cfg_data = 2'b01;
    in_valid = 1'b1; in_data = 16'h0004;
    #1;
    check("wr_rdy_low", 32'(in_ready), 32'h0);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    check("rbw_old", 32'(out_data), 32'h03);
    send(16'h0004);
    tick();
    check("rbw_new", 32'(out_data), 32'h01);
    tick();

    out_ready = 1'b0;
    send(16'h0004);
    send(16'h0104);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_cnt", 32'(lookup_cnt), 32'h0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("midrst_no_pulse", 32'(out_valid), 32'h0);
    send(16'h0004);
    tick();
    check("retained", 32'(out_data), 32'h01);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_neuron = 2'($urandom);
      cfg_addr   = 4'($urandom);
      cfg_data   = 2'($urandom);
      in_valid   = 1'($urandom);
      in_data    = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("sat_reach", 32'(lookup_cnt), 32'hFFFF);
    send(16'h0004);
    repeat (3) tick();
    check("sat_hold", 32'(lookup_cnt), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
